// File: rtl/arm7_pkg.sv
// Shared ARM7 core definitions: datapath widths, fetch constants and the
// {pc, instr} pair carried from fetch to decode.
package arm7_pkg;

   localparam int ADDR_W  = 32;
   localparam int INSTR_W = 32;

   localparam logic [ADDR_W-1:0] PC_STEP          = 32'd4;
   localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef struct packed {
      logic [ADDR_W-1:0]  pc;
      logic [INSTR_W-1:0] instr;
   } fetch_entry_t;

   // Instructions are word aligned, so the two low address bits are dropped.
   function automatic logic [ADDR_W-1:0] wordAlign(input logic [ADDR_W-1:0] addr);
      return {addr[ADDR_W-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Small synchronous FIFO of fetched {pc, instr} pairs. Flush empties it and
// wins over a same-cycle push; a same-cycle pop is still honoured upstream.
module fetch_buffer
   import arm7_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push_i,
   input  fetch_entry_t                 push_data_i,
   input  logic                         pop_i,
   input  logic                         flush_i,
   output fetch_entry_t                 head_o,
   output logic [$clog2(DEPTH+1)-1:0]   count_o,
   output logic                         empty_o,
   output logic                         full_o
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   fetch_entry_t     mem_q [DEPTH];
   logic [IDX_W-1:0] rdPtr_q, rdPtr_d;
   logic [IDX_W-1:0] wrPtr_q, wrPtr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             doPush;
   logic             doPop;

   // Pointers wrap explicitly because DEPTH need not be a power of two.
   function automatic logic [IDX_W-1:0] nextIdx(input logic [IDX_W-1:0] idx);
      return (idx == IDX_W'(DEPTH-1)) ? '0 : idx + 1'b1;
   endfunction

   assign doPush = push_i & ~flush_i;
   assign doPop  = pop_i & (count_q != '0);

   always_comb begin
      rdPtr_d = rdPtr_q;
      wrPtr_d = wrPtr_q;
      count_d = count_q;
      if (flush_i) begin
         rdPtr_d = '0;
         wrPtr_d = '0;
         count_d = '0;
      end else begin
         if (doPush) wrPtr_d = nextIdx(wrPtr_q);
         if (doPop)  rdPtr_d = nextIdx(rdPtr_q);
         count_d = count_q + CNT_W'(doPush) - CNT_W'(doPop);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdPtr_q <= '0;
         wrPtr_q <= '0;
         count_q <= '0;
      end else begin
         rdPtr_q <= rdPtr_d;
         wrPtr_q <= wrPtr_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (doPush) mem_q[wrPtr_q] <= push_data_i;
   end

   assign head_o  = mem_q[rdPtr_q];
   assign count_o = count_q;
   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/fetch_stage.sv
// ARM7 instruction fetch: owns the PC, issues reads to instruction memory,
// buffers responses and hands {pc, instr} to decode; branches flush everything.
module fetch_stage
   import arm7_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int                DEPTH    = 2
) (
   input  logic               clk,
   input  logic               rst,
   output logic               imem_read_en,
   output logic [ADDR_W-1:0]  imem_read_addr,
   input  logic [INSTR_W-1:0] imem_read_instr,
   input  logic               branch_valid,
   input  logic [ADDR_W-1:0]  branch_target,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [ADDR_W-1:0]  out_pc,
   output logic [INSTR_W-1:0] out_instr
);

   localparam int CNT_W = $clog2(DEPTH+1);

   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] reqPc_q, reqPc_d;
   logic              inflight_q, inflight_d;
   fetch_entry_t      last_q, last_d;

   fetch_entry_t      head;
   fetch_entry_t      pushData;
   logic [CNT_W-1:0]  bufCount;
   logic              bufEmpty;
   logic              bufFull;
   logic              push;
   logic              pop;
   logic              issue;
   logic [CNT_W:0]    occupancy;

   // Occupancy counts the in-flight response as a reserved slot, so a read is
   // only issued when its data is guaranteed somewhere to land.
   always_comb begin
      occupancy = (CNT_W+1)'(bufCount) + (CNT_W+1)'(inflight_q) - (CNT_W+1)'(pop);
      issue     = ~rst & ~branch_valid & (occupancy < (CNT_W+1)'(DEPTH));
   end

   assign pop      = out_valid & out_ready;
   assign push     = inflight_q & ~branch_valid;
   assign pushData = '{pc: reqPc_q, instr: imem_read_instr};

   always_comb begin
      pc_d       = pc_q;
      reqPc_d    = reqPc_q;
      inflight_d = 1'b0;
      if (branch_valid) begin
         pc_d = wordAlign(branch_target);
      end else if (issue) begin
         pc_d       = pc_q + PC_STEP;
         reqPc_d    = pc_q;
         inflight_d = 1'b1;
      end
   end

   // Decode sees the last presented entry again whenever the buffer runs dry.
   always_comb begin
      last_d = last_q;
      if (!bufEmpty) last_d = head;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q       <= RESET_PC;
         reqPc_q    <= RESET_PC;
         inflight_q <= 1'b0;
         last_q     <= '0;
      end else begin
         pc_q       <= pc_d;
         reqPc_q    <= reqPc_d;
         inflight_q <= inflight_d;
         last_q     <= last_d;
      end
   end

   fetch_buffer #(
      .DEPTH (DEPTH)
   ) u_buf (
      .clk         (clk),
      .rst         (rst),
      .push_i      (push),
      .push_data_i (pushData),
      .pop_i       (pop),
      .flush_i     (branch_valid),
      .head_o      (head),
      .count_o     (bufCount),
      .empty_o     (bufEmpty),
      .full_o      (bufFull)
   );

   assign imem_read_en   = issue;
   assign imem_read_addr = pc_q;
   assign out_valid      = ~bufEmpty;
   assign out_pc         = bufEmpty ? last_q.pc    : head.pc;
   assign out_instr      = bufEmpty ? last_q.instr : head.instr;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed and randomised checks of fetch_stage against a registered-read
// memory model whose word at address A is 32'hE3A0_0000 | A.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        outReady = 1'b1;
   logic        branchValid = 1'b0;
   logic [31:0] branchTarget = '0;

   logic        readEn;
   logic [31:0] readAddr;
   logic [31:0] memData = '0;
   logic        outValid;
   logic [31:0] outPc;
   logic [31:0] outInstr;

   logic        wReadEn;
   logic [31:0] wReadAddr;
   logic [31:0] wMemData = '0;
   logic        wOutValid;
   logic [31:0] wOutPc;
   logic [31:0] wOutInstr;

   int checks = 0;
   int errors = 0;

   fetch_stage #(.RESET_PC(32'h0000_0000), .DEPTH(3)) dut (
      .clk             (clk),
      .rst             (rst),
      .imem_read_en    (readEn),
      .imem_read_addr  (readAddr),
      .imem_read_instr (memData),
      .branch_valid    (branchValid),
      .branch_target   (branchTarget),
      .out_valid       (outValid),
      .out_ready       (outReady),
      .out_pc          (outPc),
      .out_instr       (outInstr)
   );

   fetch_stage #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) dutWrap (
      .clk             (clk),
      .rst             (rst),
      .imem_read_en    (wReadEn),
      .imem_read_addr  (wReadAddr),
      .imem_read_instr (wMemData),
      .branch_valid    (1'b0),
      .branch_target   (32'h0000_0000),
      .out_valid       (wOutValid),
      .out_ready       (1'b1),
      .out_pc          (wOutPc),
      .out_instr       (wOutInstr)
   );

   always #5 clk = ~clk;

   // Registered-read instruction memories, one per instance.
   always @(posedge clk) begin
      if (readEn)  memData  <= 32'hE3A0_0000 | readAddr;
      if (wReadEn) wMemData <= 32'hE3A0_0000 | wReadAddr;
   end

   function automatic logic [31:0] memWord(input logic [31:0] addr);
      return 32'hE3A0_0000 | addr;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // One cycle: drive inputs just after the falling edge, then let them settle.
   task automatic applyStimulus(input logic ready, input logic br, input logic [31:0] tgt);
      @(negedge clk);
      rst          = 1'b0;
      outReady     = ready;
      branchValid  = br;
      branchTarget = tgt;
      #1;
   endtask

   task automatic resetDut();
      rst         = 1'b1;
      branchValid = 1'b0;
      repeat (2) @(negedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] expPc;
      logic [31:0] tgt;
      logic        rdy;
      logic        br;

      // Reset state while rst is held.
      resetDut();
      checkOutput("rst readEn", 32'(readEn), 32'd0);
      checkOutput("rst outValid", 32'(outValid), 32'd0);
      checkOutput("rst outPc", outPc, 32'd0);
      checkOutput("rst outInstr", outInstr, 32'd0);
      checkOutput("rst wrap outValid", 32'(wOutValid), 32'd0);

      // Streaming from reset, plus the wrapping instance alongside.
      for (int c = 0; c < 6; c++) begin
         applyStimulus(1'b1, 1'b0, 32'd0);
         checkOutput("stream readEn", 32'(readEn), 32'd1);
         checkOutput("stream addr", readAddr, 32'(4 * c));
         checkOutput("stream outValid", 32'(outValid), (c >= 2) ? 32'd1 : 32'd0);
         checkOutput("wrap addr", wReadAddr, 32'hFFFF_FFF8 + 32'(4 * c));
         checkOutput("wrap outValid", 32'(wOutValid), (c >= 2) ? 32'd1 : 32'd0);
         if (c >= 2) begin
            checkOutput("stream outPc", outPc, 32'(4 * (c - 2)));
            checkOutput("stream outInstr", outInstr, memWord(32'(4 * (c - 2))));
            checkOutput("wrap outPc", wOutPc, 32'hFFFF_FFF8 + 32'(4 * (c - 2)));
            checkOutput("wrap outInstr", wOutInstr, memWord(32'hFFFF_FFF8 + 32'(4 * (c - 2))));
         end
      end

      // Back-pressure: decode stalls for cycles 2..6.
      resetDut();
      for (int c = 0; c <= 10; c++) begin
         applyStimulus((c < 2 || c >= 7), 1'b0, 32'd0);
         checkOutput("bp readEn", 32'(readEn), (c >= 3 && c <= 6) ? 32'd0 : 32'd1);
         if (c >= 2) begin
            expPc = (c <= 7) ? 32'd0 : 32'(4 * (c - 7));
            checkOutput("bp outValid", 32'(outValid), 32'd1);
            checkOutput("bp outPc", outPc, expPc);
            checkOutput("bp outInstr", outInstr, memWord(expPc));
         end
         if (c == 7) checkOutput("bp resume addr", readAddr, 32'd12);
      end

      // Branch with two entries buffered and one read in flight.
      resetDut();
      applyStimulus(1'b1, 1'b0, 32'd0);
      applyStimulus(1'b1, 1'b0, 32'd0);
      applyStimulus(1'b0, 1'b0, 32'd0);
      applyStimulus(1'b0, 1'b1, 32'h0000_0103);
      checkOutput("br readEn", 32'(readEn), 32'd0);
      checkOutput("br outPc before", outPc, 32'd0);
      applyStimulus(1'b1, 1'b0, 32'd0);
      checkOutput("br+1 outValid", 32'(outValid), 32'd0);
      checkOutput("br+1 readEn", 32'(readEn), 32'd1);
      checkOutput("br+1 addr", readAddr, 32'h0000_0100);
      applyStimulus(1'b1, 1'b0, 32'd0);
      checkOutput("br+2 outValid", 32'(outValid), 32'd0);
      checkOutput("br+2 addr", readAddr, 32'h0000_0104);
      applyStimulus(1'b1, 1'b0, 32'd0);
      checkOutput("br+3 outValid", 32'(outValid), 32'd1);
      checkOutput("br+3 outPc", outPc, 32'h0000_0100);
      checkOutput("br+3 outInstr", outInstr, 32'hE3A0_0100);
      applyStimulus(1'b1, 1'b0, 32'd0);
      checkOutput("br+4 outPc", outPc, 32'h0000_0104);
      checkOutput("br+4 outInstr", outInstr, 32'hE3A0_0104);

      // Asynchronous reset between clock edges.
      for (int c = 0; c < 4; c++) applyStimulus(1'b1, 1'b0, 32'd0);
      checkOutput("pre-arst outValid", 32'(outValid), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("arst readEn", 32'(readEn), 32'd0);
      checkOutput("arst outValid", 32'(outValid), 32'd0);
      checkOutput("arst outPc", outPc, 32'd0);
      resetDut();
      for (int c = 0; c < 3; c++) begin
         applyStimulus(1'b1, 1'b0, 32'd0);
         checkOutput("restart addr", readAddr, 32'(4 * c));
      end
      checkOutput("restart outPc", outPc, 32'd0);
      checkOutput("restart outInstr", outInstr, 32'hE3A0_0000);

      // Random back-pressure and redirects with an in-order pc scoreboard.
      resetDut();
      expPc = 32'd0;
      for (int n = 0; n < 2000; n++) begin
         rdy = ($urandom_range(0, 3) != 0);
         br  = ($urandom_range(0, 39) == 0);
         tgt = $urandom_range(0, 32'h0000_FFFF);
         applyStimulus(rdy, br, tgt);
         if (outValid && outReady) begin
            checkOutput("stress outPc", outPc, expPc);
            checkOutput("stress outInstr", outInstr, memWord(expPc));
            expPc = expPc + 32'd4;
         end
         checkOutput("stress overflow", 32'(dut.push & dut.bufFull & ~dut.pop), 32'd0);
         if (br) expPc = {tgt[31:2], 2'b00};
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
